// File: rtl/cfg_chain_loader.sv
// Serial loader that drives CHAIN_LEN bits, LSB first, into the PE config chain, with an optional chain clear first.
// Latency: done = (clear ? RST_CYCLES : 0) + fetch cycles + 2*CHAIN_LEN + 1 cycles after start; every output is a flop.
// Backpressure: s_ready only in FETCH; with no word offered the loader stalls indefinitely with config_clk held low.
module cfg_chain_loader #(
    parameter int WORD_W     = 32,
    parameter int CHAIN_LEN  = 1024,
    parameter int RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear_first,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              config_clk,
    output logic              config_reset,
    output logic              config_in,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int BIT_W = $clog2(CHAIN_LEN + 1);
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN);
    localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(RST_CYCLES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_SETUP = 3'd3;
    localparam logic [2:0] ST_HIGH  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [1:0]        rst_sync;
    logic              rst_ok;
    logic [2:0]        state, state_n;
    logic [RC_W-1:0]   rcnt, rcnt_n;
    logic [WORD_W-1:0] word, word_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [BIT_W-1:0]  bits, bits_n, bits_inc;
    logic              cin_n;

    // Release of reset is synchronised so the FSM leaves IDLE no earlier than the 3rd edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_ok   = rst_sync[1];
    assign bits_inc = bits + BIT_W'(1);

    always_comb begin
        state_n = state;
        rcnt_n  = rcnt;
        word_n  = word;
        idx_n   = idx;
        bits_n  = bits;
        case (state)
            ST_IDLE: begin
                bits_n = '0;
                if (rst_ok && start) begin
                    if (clear_first) begin
                        state_n = ST_CLR;
                        rcnt_n  = RC_LOAD;
                    end else begin
                        state_n = ST_FETCH;
                    end
                end
            end
            ST_CLR: begin
                if (rcnt == '0) state_n = ST_FETCH;
                else            rcnt_n  = rcnt - RC_W'(1);
            end
            ST_FETCH: begin
                if (s_valid && s_ready) begin
                    word_n  = s_data;
                    idx_n   = '0;
                    state_n = ST_SETUP;
                end
            end
            ST_SETUP: state_n = ST_HIGH;
            ST_HIGH: begin
                bits_n = bits_inc;
                if (bits_inc == BIT_LAST) begin
                    state_n = ST_DONE;
                end else if (idx == IDX_LAST) begin
                    state_n = ST_FETCH;
                end else begin
                    idx_n   = idx + IDX_W'(1);
                    word_n  = word >> 1;
                    state_n = ST_SETUP;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        // Data is presented in SETUP and held through HIGH so it is stable at the chain's rising edge.
        cin_n = config_in;
        if (state_n == ST_SETUP)     cin_n = word_n[0];
        else if (state_n == ST_IDLE) cin_n = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            rcnt         <= '0;
            word         <= '0;
            idx          <= '0;
            bits         <= '0;
            s_ready      <= 1'b0;
            config_clk   <= 1'b0;
            config_reset <= 1'b0;
            config_in    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            rcnt         <= rcnt_n;
            word         <= word_n;
            idx          <= idx_n;
            bits         <= bits_n;
            s_ready      <= (state_n == ST_FETCH);
            config_clk   <= (state_n == ST_HIGH);
            config_reset <= (state_n == ST_CLR);
            config_in    <= cin_n;
            busy         <= (state_n != ST_IDLE);
            done         <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: three instances (6, 8 and 27-bit chains) share one stimulus path selected by sel;
// expected config_in bits go into a scoreboard queue that a monitor pops at every config_clk rise.
module tb_cfg_chain_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       clear_first = 1'b0;
    logic [3:0] s_data = 4'h0;
    logic       s_valid = 1'b0;
    logic [1:0] sel = 2'd0;

    logic [2:0] sel_oh, st_v, sv_v;
    logic [2:0] rdy, cclk, crst, cin, bsy, dn;
    logic       m_rdy, m_cclk, m_crst, m_cin, m_bsy, m_dn;
    logic [17:0] all_outs;

    always #5 clk = ~clk;

    assign sel_oh   = 3'b001 << sel;
    assign st_v     = {3{start}} & sel_oh;
    assign sv_v     = {3{s_valid}} & sel_oh;
    assign m_rdy    = rdy[sel];
    assign m_cclk   = cclk[sel];
    assign m_crst   = crst[sel];
    assign m_cin    = cin[sel];
    assign m_bsy    = bsy[sel];
    assign m_dn     = dn[sel];
    assign all_outs = {rdy, cclk, crst, cin, bsy, dn};

    cfg_chain_loader #(.WORD_W(4), .CHAIN_LEN(6), .RST_CYCLES(2)) u_a (
        .clk(clk), .reset(reset), .start(st_v[0]), .clear_first(clear_first),
        .s_data(s_data), .s_valid(sv_v[0]), .s_ready(rdy[0]), .config_clk(cclk[0]),
        .config_reset(crst[0]), .config_in(cin[0]), .busy(bsy[0]), .done(dn[0]));

    cfg_chain_loader #(.WORD_W(4), .CHAIN_LEN(8), .RST_CYCLES(2)) u_b (
        .clk(clk), .reset(reset), .start(st_v[1]), .clear_first(clear_first),
        .s_data(s_data), .s_valid(sv_v[1]), .s_ready(rdy[1]), .config_clk(cclk[1]),
        .config_reset(crst[1]), .config_in(cin[1]), .busy(bsy[1]), .done(dn[1]));

    cfg_chain_loader #(.WORD_W(4), .CHAIN_LEN(27), .RST_CYCLES(4)) u_c (
        .clk(clk), .reset(reset), .start(st_v[2]), .clear_first(clear_first),
        .s_data(s_data), .s_valid(sv_v[2]), .s_ready(rdy[2]), .config_clk(cclk[2]),
        .config_reset(crst[2]), .config_in(cin[2]), .busy(bsy[2]), .done(dn[2]));

    // Three 9-bit PEs in series behind u_c; chain[26] is the far end (final config_out).
    logic [26:0] chain = '0;
    logic        rb_q[$];
    always @(posedge cclk[2] or posedge crst[2]) begin
        if (crst[2]) chain <= '0;
        else begin
            rb_q.push_back(chain[26]);
            chain <= {chain[25:0], cin[2]};
        end
    end

    int   tests = 0;
    int   errors = 0;
    logic exp_q[$];
    logic [3:0] wq[$];
    int   feed_stall = 0;
    bit   extra_vld = 0;
    logic [3:0] extra_word = 4'h0;
    bit   mon_en = 0;
    logic prev_cclk = 1'b0;
    int   rise_cnt = 0, rst_cnt = 0, rdy_cyc = 0, hs_cnt = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard at each config_clk rise and tallies per-load activity.
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_cclk && !prev_cclk) begin
                rise_cnt++;
                if (exp_q.size() == 0) chk("unexpected_config_clk_rise", 1, 0);
                else chk("config_in_at_rise", m_cin, exp_q.pop_front());
            end
            if (m_crst) rst_cnt++;
            if (m_rdy) rdy_cyc++;
            if (m_rdy && s_valid) hs_cnt++;
        end
        prev_cclk = m_cclk;
    end

    task automatic feed();
        int t;
        while (wq.size() > 0) begin
            s_data  = wq[0];
            s_valid = (feed_stall == 0);
            t = 0;
            do begin @(negedge clk); t++; end while (!m_rdy && t < 500);
            if (!m_rdy) begin
                chk("feed_wait_s_ready_timeout", 0, 1);
                s_valid = 1'b0;
                wq.delete();
                return;
            end
            if (feed_stall > 0) begin
                repeat (feed_stall) @(posedge clk);
                #1 s_valid = 1'b1;
            end
            @(posedge clk);
            #1 void'(wq.pop_front());
            s_valid = 1'b0;
        end
        if (extra_vld) begin
            s_data  = extra_word;
            s_valid = 1'b1;
        end
    endtask

    task automatic run_load(input logic [1:0] s, input logic clr, input int stall, input int exp_lat,
                            input int exp_f, input int exp_rises, input int exp_rst, input bit retrig,
                            input string nm);
        int lat;
        sel = s;
        feed_stall = stall;
        @(negedge clk);
        rst_cnt = 0; hs_cnt = 0; rdy_cyc = 0; rise_cnt = 0;
        start = 1'b1;
        clear_first = clr;
        @(posedge clk);
        #1 start = 1'b0;
        fork feed(); join_none
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (retrig && lat == 5) start = 1'b1;
            else if (retrig && lat == 6) start = 1'b0;
        end while (!m_dn && lat < 2000);
        chk({nm, "_done_latency"}, lat, exp_lat);
        chk({nm, "_config_clk_rises"}, rise_cnt, exp_rises);
        chk({nm, "_config_reset_cycles"}, rst_cnt, exp_rst);
        chk({nm, "_fetch_cycles"}, rdy_cyc, exp_f);
        chk({nm, "_handshakes"}, hs_cnt, (exp_rises + 3) / 4);
        chk({nm, "_bits_left_in_scoreboard"}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] st1, st2;
        logic [26:0] exp_chain, rb_vec;
        int t;

        // Reset held low with random inputs: everything quiet.
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start   = 1'($urandom_range(0, 1));
            s_valid = 1'($urandom_range(0, 1));
            sel     = 2'($urandom_range(0, 2));
            #1 chk("outputs_during_reset", all_outs, 0);
        end

        // Release: start is honoured on the 3rd edge after reset rises.
        @(negedge clk);
        sel = 2'd0; start = 1'b1; clear_first = 1'b0; s_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1 chk("busy_edge1_after_release", m_bsy, 0);
        @(posedge clk); #1 chk("busy_edge2_after_release", m_bsy, 0);
        @(posedge clk); #1 chk("busy_edge3_after_release", m_bsy, 1);
        start = 1'b0;

        // Reset mid-HIGH: config_clk drops without a clock edge.
        s_data = 4'hF; s_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!m_cclk && t < 50);
        chk("reached_high_state", m_cclk, 1);
        #2 reset = 1'b0;
        #1 chk("config_clk_async_fall", m_cclk, 0);
        chk("outputs_after_async_reset", all_outs, 0);
        s_valid = 1'b0;
        @(negedge clk) reset = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.delete();
        mon_en = 1;

        // Basic load with clear: 0xA then 0x3, LSB first -> 0,1,0,1,1,1.
        wq = '{4'hA, 4'h3};
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        run_load(2'd0, 1'b1, 0, 17, 2, 6, 2, 1'b0, "basic");

        // Stalled stream: 5 idle FETCH cycles before each word.
        wq = '{4'hA, 4'h3};
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        run_load(2'd0, 1'b0, 5, 25, 12, 6, 0, 1'b0, "stalled");

        // Exact multiple: 8 bits, a third word offered and never taken.
        wq = '{4'h5, 4'hC};
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        extra_vld = 1; extra_word = 4'h9;
        run_load(2'd1, 1'b0, 0, 19, 2, 8, 0, 1'b0, "exact");
        repeat (4) @(negedge clk);
        chk("exact_handshakes_after_surplus", hs_cnt, 2);
        chk("exact_s_ready_cycles_after_surplus", rdy_cyc, 2);
        s_valid = 1'b0; extra_vld = 0;

        // Retrigger: start pulsed mid-shift and on the done cycle is ignored; next cycle starts a new load.
        wq = '{4'h6, 4'h1};
        exp_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        run_load(2'd0, 1'b0, 0, 15, 2, 6, 0, 1'b1, "retrig_mid");
        start = 1'b1;
        @(posedge clk); #1 chk("start_on_done_ignored", m_bsy, 0);
        wq = '{4'h9, 4'h2};
        exp_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_load(2'd0, 1'b0, 0, 15, 2, 6, 0, 1'b0, "retrig_next");

        // Chain integration: 3 PEs x 9 bits.
        st1 = 28'($urandom);
        st2 = 28'($urandom);
        for (int k = 0; k < 7; k++) wq.push_back(st1[4*k +: 4]);
        for (int b = 0; b < 27; b++) begin
            exp_q.push_back(st1[b]);
            exp_chain[26-b] = st1[b];
        end
        run_load(2'd2, 1'b1, 1, 73, 14, 27, 4, 1'b0, "chain1");
        chk("pe0_config_sig", chain[8:0], exp_chain[8:0]);
        chk("pe1_config_sig", chain[17:9], exp_chain[17:9]);
        chk("pe2_config_sig", chain[26:18], exp_chain[26:18]);

        rb_q.delete();
        for (int k = 0; k < 7; k++) wq.push_back(st2[4*k +: 4]);
        for (int b = 0; b < 27; b++) begin
            exp_q.push_back(st2[b]);
            exp_chain[26-b] = st2[b];
        end
        run_load(2'd2, 1'b0, 0, 62, 7, 27, 0, 1'b0, "chain2");
        chk("readback_count", rb_q.size(), 27);
        rb_vec = '0;
        for (int b = 0; b < 27 && b < rb_q.size(); b++) rb_vec[b] = rb_q[b];
        chk("readback_stream", rb_vec, st1[26:0]);
        chk("chain_after_reload", chain, exp_chain);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
